// File: rtl/demux_pkg.sv
// Shared definitions for the buffered 1-to-4 demultiplexer:
// channel encodings, FIFO sizing and the select decode.
package demux_pkg;

  typedef enum logic [1:0] {
    CH0 = 2'd0,
    CH1 = 2'd1,
    CH2 = 2'd2,
    CH3 = 2'd3
  } chan_e;

  localparam int FIFO_DEPTH = 2;
  localparam int COUNT_W    = 2;

  localparam logic [COUNT_W-1:0] COUNT_FULL  = 2'd2;
  localparam logic [COUNT_W-1:0] COUNT_EMPTY = 2'd0;

  // One-hot decode of a channel code; bit k set when sel targets channel k.
  function automatic logic [3:0] chan_decode(input logic [1:0] sel);
    logic [3:0] onehot;
    onehot = 4'b0000;
    case (chan_e'(sel))
      CH0: onehot = 4'b0001;
      CH1: onehot = 4'b0010;
      CH2: onehot = 4'b0100;
      CH3: onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Two-entry per-channel FIFO: 1-bit read/write pointers, 2-bit count.
// Push while full and pop while empty are ignored, so count stays within 0..2.
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int size = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [size-1:0]    data_in,
  output logic [size-1:0]    data_out,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  logic [size-1:0] mem [FIFO_DEPTH];
  logic            wr_ptr;
  logic            rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full     = (count == COUNT_FULL);
  assign empty    = (count == COUNT_EMPTY);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= COUNT_EMPTY;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_1to4_buf.sv
// Buffered 1-to-4 demux: routes one valid/ready stream into four independent
// 2-entry channel FIFOs selected by select_i.
module demux_1to4_buf
  import demux_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [size-1:0] data_i,
  input  logic [1:0]      select_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [size-1:0] data0_o,
  output logic [size-1:0] data1_o,
  output logic [size-1:0] data2_o,
  output logic [size-1:0] data3_o,
  output logic            valid0_o,
  output logic            valid1_o,
  output logic            valid2_o,
  output logic            valid3_o,
  input  logic            ready0_i,
  input  logic            ready1_i,
  input  logic            ready2_i,
  input  logic            ready3_i,
  output logic [7:0]      occupancy_o
);

  logic [COUNT_W-1:0] count   [4];
  logic [size-1:0]    data_ch [4];
  logic [3:0]         full;
  logic [3:0]         empty;
  logic [3:0]         push_en;
  logic [3:0]         pop_req;

  // ready_o looks only at registered counts, never at the consumer readies.
  assign ready_o = !full[select_i];
  assign push_en = (valid_i && ready_o) ? chan_decode(select_i) : 4'b0000;
  assign pop_req = {ready3_i, ready2_i, ready1_i, ready0_i};

  for (genvar k = 0; k < 4; k++) begin : g_chan
    demux_chan_fifo #(.size(size)) u_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .push     (push_en[k]),
      .pop      (pop_req[k]),
      .data_in  (data_i),
      .data_out (data_ch[k]),
      .count    (count[k]),
      .full     (full[k]),
      .empty    (empty[k])
    );
  end

  assign data0_o  = data_ch[0];
  assign data1_o  = data_ch[1];
  assign data2_o  = data_ch[2];
  assign data3_o  = data_ch[3];
  assign valid0_o = !empty[0];
  assign valid1_o = !empty[1];
  assign valid2_o = !empty[2];
  assign valid3_o = !empty[3];

  assign occupancy_o = {count[3], count[2], count[1], count[0]};

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Directed bench for demux_1to4_buf: routing, backpressure, push/pop overlap,
// channel isolation and mid-stream reset, checked against hand-computed values.
module tb_demux_1to4_buf;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic [1:0]  select_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data0_o, data1_o, data2_o, data3_o;
  logic        valid0_o, valid1_o, valid2_o, valid3_o;
  logic        ready0_i, ready1_i, ready2_i, ready3_i;
  logic [7:0]  occupancy_o;

  int n_total = 0;
  int n_pass  = 0;

  demux_1to4_buf #(.size(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .select_i    (select_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data0_o     (data0_o),
    .data1_o     (data1_o),
    .data2_o     (data2_o),
    .data3_o     (data3_o),
    .valid0_o    (valid0_o),
    .valid1_o    (valid1_o),
    .valid2_o    (valid2_o),
    .valid3_o    (valid3_o),
    .ready0_i    (ready0_i),
    .ready1_i    (ready1_i),
    .ready2_i    (ready2_i),
    .ready3_i    (ready3_i),
    .occupancy_o (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] sel);
    data_i   = d;
    select_i = sel;
    valid_i  = 1'b1;
    step();
    valid_i  = 1'b0;
  endtask

  function automatic logic [3:0] valids();
    return {valid3_o, valid2_o, valid1_o, valid0_o};
  endfunction

  initial begin
    rst_i = 1'b1; data_i = '0; select_i = 2'd0; valid_i = 1'b0;
    ready0_i = 1'b0; ready1_i = 1'b0; ready2_i = 1'b0; ready3_i = 1'b0;
    step();
    rst_i = 1'b0;

    // Reset state
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_valid", {28'd0, valids()}, 32'h0);
    chk("rst_occ", {24'd0, occupancy_o}, 32'h00);
    chk("rst_data0", data0_o, 32'h0);
    chk("rst_data1", data1_o, 32'h0);
    chk("rst_data2", data2_o, 32'h0);
    chk("rst_data3", data3_o, 32'h0);

    // Routing and 1-cycle latency
    push(32'hA0, 2'd0);
    chk("route0_v", {28'd0, valids()}, 32'h1);
    chk("route0_d", data0_o, 32'hA0);
    push(32'hA1, 2'd1);
    chk("route1_v", {28'd0, valids()}, 32'h3);
    chk("route1_d", data1_o, 32'hA1);
    push(32'hA2, 2'd2);
    chk("route2_v", {28'd0, valids()}, 32'h7);
    chk("route2_d", data2_o, 32'hA2);
    push(32'hA3, 2'd3);
    chk("route3_v", {28'd0, valids()}, 32'hF);
    chk("route3_d", data3_o, 32'hA3);
    chk("route_occ", {24'd0, occupancy_o}, 32'h55);
    chk("route_d0_kept", data0_o, 32'hA0);

    // Drain everything in one cycle
    {ready3_i, ready2_i, ready1_i, ready0_i} = 4'hF;
    step();
    {ready3_i, ready2_i, ready1_i, ready0_i} = 4'h0;
    chk("drain_occ", {24'd0, occupancy_o}, 32'h00);
    chk("drain_valid", {28'd0, valids()}, 32'h0);

    // Backpressure on channel 2
    select_i = 2'd2;
    #1 chk("bp_ready_e0", {31'd0, ready_o}, 32'd1);
    push(32'h11, 2'd2);
    chk("bp_ready_e1", {31'd0, ready_o}, 32'd1);
    push(32'h22, 2'd2);
    chk("bp_ready_full", {31'd0, ready_o}, 32'd0);
    chk("bp_occ_full", {24'd0, occupancy_o}, 32'h20);
    data_i = 32'h33; select_i = 2'd2; valid_i = 1'b1;
    step();
    chk("bp_held_ready", {31'd0, ready_o}, 32'd0);
    chk("bp_held_occ", {24'd0, occupancy_o}, 32'h20);
    chk("bp_head11", data2_o, 32'h11);
    ready2_i = 1'b1;
    step();
    chk("bp_pop11_head", data2_o, 32'h22);
    chk("bp_pop11_occ", {24'd0, occupancy_o}, 32'h10);
    chk("bp_ready_back", {31'd0, ready_o}, 32'd1);
    step();
    valid_i = 1'b0;
    chk("bp_head33", data2_o, 32'h33);
    chk("bp_occ33", {24'd0, occupancy_o}, 32'h10);
    step();
    ready2_i = 1'b0;
    chk("bp_empty", {24'd0, occupancy_o}, 32'h00);
    chk("bp_valid2", {31'd0, valid2_o}, 32'd0);

    // Simultaneous push/pop at count 1 on channel 1
    push(32'h5, 2'd1);
    chk("pp_head5", data1_o, 32'h5);
    chk("pp_occ1", {24'd0, occupancy_o}, 32'h04);
    ready1_i = 1'b1;
    push(32'h6, 2'd1);
    ready1_i = 1'b0;
    chk("pp_occ_same", {24'd0, occupancy_o}, 32'h04);
    chk("pp_head6", data1_o, 32'h6);

    // Channel isolation: ch0 full and stalled, ch3 streams
    push(32'hC0, 2'd0);
    push(32'hC1, 2'd0);
    chk("iso_occ0_full", {30'd0, occupancy_o[1:0]}, 32'd2);
    ready3_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      select_i = 2'd3;
      #1 chk($sformatf("iso_ready%0d", i), {31'd0, ready_o}, 32'd1);
      push(32'hD0 + i, 2'd3);
      chk($sformatf("iso_d3_%0d", i), data3_o, 32'hD0 + i);
      chk($sformatf("iso_occ3_%0d", i), {30'd0, occupancy_o[7:6]}, 32'd1);
      chk($sformatf("iso_d0_%0d", i), data0_o, 32'hC0);
      chk($sformatf("iso_occ0_%0d", i), {30'd0, occupancy_o[1:0]}, 32'd2);
    end
    step();
    ready3_i = 1'b0;
    chk("iso_drained3", {31'd0, valid3_o}, 32'd0);
    chk("iso_occ_end", {24'd0, occupancy_o}, 32'h06);

    // Fill to 8'hAA, then reset mid-stream
    push(32'hE1, 2'd1);
    push(32'hE2, 2'd2);
    push(32'hE3, 2'd2);
    push(32'hE4, 2'd3);
    push(32'hE5, 2'd3);
    chk("pre_rst_occ", {24'd0, occupancy_o}, 32'hAA);
    chk("pre_rst_d3", data3_o, 32'hE4);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mrst_occ", {24'd0, occupancy_o}, 32'h00);
    chk("mrst_valid", {28'd0, valids()}, 32'h0);
    chk("mrst_ready", {31'd0, ready_o}, 32'd1);
    chk("mrst_data0", data0_o, 32'h0);
    push(32'h77, 2'd0);
    chk("post_valid", {28'd0, valids()}, 32'h1);
    chk("post_data0", data0_o, 32'h77);
    chk("post_occ", {24'd0, occupancy_o}, 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
